// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: recovers the signed duty word and period of a PWM line.
// Reports a stalled line as stuck and tracks its level while stalled.
module pwm_duty_decoder #(
  parameter int M       = 1000,
  parameter int W       = 10,
  parameter int CW      = 16,
  parameter int TIMEOUT = 4000,
  parameter int SYNC    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm_in,
  output logic signed [W-1:0] duty,
  output logic [CW-1:0]       period,
  output logic                valid,
  output logic                stuck
);

  localparam int HALF = M / 2;
  localparam int CW1  = CW + 1;

  localparam logic signed [CW:0]  POS  = CW1'(HALF);
  localparam logic signed [CW:0]  NEG  = CW1'(-HALF);
  localparam logic signed [W-1:0] DPOS = W'(HALF);
  localparam logic signed [W-1:0] DNEG = W'(-HALF);
  localparam logic [CW-1:0]       TO   = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    STUCK
  } state_t;

  state_t state, state_n;

  logic [SYNC-1:0] sync_q;
  logic            s;
  logic            s_d;
  logic            rise;
  logic            fall;
  logic            timeout;

  logic [CW-1:0]       cnt;
  logic [CW-1:0]       hi, hi_n;
  logic signed [CW:0]  diff;
  logic signed [W-1:0] duty_n;
  logic [CW-1:0]       period_n;
  logic                valid_n;
  logic                stuck_n;

  assign s       = sync_q[SYNC-1];
  assign rise    = s & ~s_d;
  assign fall    = ~s & s_d;
  assign timeout = (cnt == TO) & ~rise & ~fall;

  assign diff = $signed({1'b0, hi})
              - $signed({2'b00, cnt[CW-1:1]});

  // Synchronize the asynchronous line and keep one cycle of history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], pwm_in};
      s_d    <= s;
    end
  end

  // Cycles since the last rise, saturating at the stall limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CW'(1);
    end else if (cnt < TO) begin
      cnt <= cnt + CW'(1);
    end
  end

  // State, latched high time and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hi     <= '0;
      duty   <= '0;
      period <= '0;
      valid  <= 1'b0;
      stuck  <= 1'b0;
    end else begin
      state  <= state_n;
      hi     <= hi_n;
      duty   <= duty_n;
      period <= period_n;
      valid  <= valid_n;
      stuck  <= stuck_n;
    end
  end

  // Next state and next outputs; outputs hold unless a strobe fires.
  always_comb begin
    state_n  = state;
    hi_n     = hi;
    duty_n   = duty;
    period_n = period;
    valid_n  = 1'b0;
    stuck_n  = stuck;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n = HIGH;
        end else if (timeout) begin
          state_n  = STUCK;
          stuck_n  = 1'b1;
          period_n = '0;
          duty_n   = s ? DPOS : DNEG;
          valid_n  = 1'b1;
        end
      end
      HIGH: begin
        if (fall) begin
          hi_n    = cnt;
          state_n = LOW;
        end else if (timeout) begin
          state_n  = STUCK;
          stuck_n  = 1'b1;
          period_n = '0;
          duty_n   = s ? DPOS : DNEG;
          valid_n  = 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          period_n = cnt;
          valid_n  = 1'b1;
          state_n  = HIGH;
          if (diff > POS) begin
            duty_n = DPOS;
          end else if (diff < NEG) begin
            duty_n = DNEG;
          end else begin
            duty_n = diff[W-1:0];
          end
        end else if (timeout) begin
          state_n  = STUCK;
          stuck_n  = 1'b1;
          period_n = '0;
          duty_n   = s ? DPOS : DNEG;
          valid_n  = 1'b1;
        end
      end
      STUCK: begin
        if (rise) begin
          stuck_n = 1'b0;
          state_n = HIGH;
        end else if (fall) begin
          duty_n  = DNEG;
          valid_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: directed PWM waveforms with a queued scoreboard.
// Expected records are queued at stimulus time and popped on each valid.
module tb_pwm_duty_decoder;

  logic               clk;
  logic               rst;
  logic               pwm_in;
  logic signed [9:0]  duty;
  logic [15:0]        period;
  logic               valid;
  logic               stuck;

  pwm_duty_decoder #(
    .M(1000), .W(10), .CW(16), .TIMEOUT(4000), .SYNC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pwm_in(pwm_in),
    .duty(duty),
    .period(period),
    .valid(valid),
    .stuck(stuck)
  );

  typedef struct {
    int duty;
    int period;
    int stuck;
    int gap;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_v = 0;

  int   prev_d;
  int   prev_p;
  logic armed = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int d, input int p, input int st, input int g);
    exp_t e;
    e.duty   = d;
    e.period = p;
    e.stuck  = st;
    e.gap    = g;
    q.push_back(e);
  endtask

  // A rise closes the previous period; queue its result first.
  task automatic close_prev();
    if (armed) push(prev_d, prev_p, 0, 0);
    armed = 1'b0;
  endtask

  task automatic pulse(input int h, input int l, input int d, input int p);
    close_prev();
    prev_d = d;
    prev_p = p;
    armed  = 1'b1;
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_duty"}, int'(duty), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_stuck"}, int'(stuck), 0);
  endtask

  // Monitor: every valid strobe must match the oldest queued record.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: duty %0d period %0d at cycle %0d",
                 duty, period, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("duty", int'(duty), e.duty);
        chk("period", int'(period), e.period);
        chk("stuck", int'(stuck), e.stuck);
        if (e.gap != 0) chk("valid_gap", cyc - last_v, e.gap);
      end
      last_v = cyc;
    end
  end

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");

    repeat (5) pulse(750, 250, 250, 1000);
    pulse(500, 500, 0, 1000);
    pulse(1, 999, -499, 1000);
    pulse(999, 1, 499, 1000);
    pulse(400, 601, -100, 1001);
    pulse(2900, 100, 500, 3000);
    pulse(750, 250, 250, 1000);

    close_prev();
    push(500, 0, 1, 4000);
    pwm_in = 1'b1;
    repeat (5000) @(negedge clk);
    push(-500, 0, 1, 1000);
    pwm_in = 1'b0;
    repeat (500) @(negedge clk);

    pulse(750, 250, 250, 1000);
    pulse(750, 250, 250, 1000);
    close_prev();
    pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midrst");
    pwm_in = 1'b0;
    repeat (100) @(negedge clk);

    pulse(750, 250, 250, 1000);
    pulse(400, 601, -100, 1001);
    close_prev();
    pwm_in = 1'b1;
    repeat (50) @(negedge clk);

    chk("queue_left", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
